// File: rtl/pipeline_skid_register_pkg.sv
// Shared parameters for the skid stage: word width and state/occupancy encodings.
// Stall/hazard logic elsewhere decodes count using the ST_* values.
package pipeline_skid_register_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        FULL  = ST_FULL
    } skid_state_t;

endpackage

// File: rtl/pipeline_skid_register_pipe_data_reg.sv
// Word register with load enable and synchronous clear; clear beats load.
// Latency 1 cycle; no handshake of its own, the owner decides when to load.
module pipe_data_reg #(
    parameter int W = pipeline_skid_register_pkg::WORD_SIZE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (ld) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipeline_skid_register.sv
// Two-slot elastic stage (main + skid) with a registered in_ready and a synchronous flush.
// Latency 1 cycle; a stall parks at most one extra word in skid, so in_ready never waits on out_ready.
module pipeline_skid_register #(
    parameter int WORD_SIZE = pipeline_skid_register_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic [1:0]           count
);

    import pipeline_skid_register_pkg::*;

    skid_state_t          state_q;
    skid_state_t          state_d;
    logic                 in_fire;
    logic                 out_fire;
    logic                 ld_main;
    logic                 ld_skid;
    logic [WORD_SIZE-1:0] main_d;
    logic [WORD_SIZE-1:0] main_q;
    logic [WORD_SIZE-1:0] skid_q;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        ld_main = 1'b0;
        ld_skid = 1'b0;
        main_d  = in_data;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    ld_main = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    ld_main = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    ld_main = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush kills any same-cycle transfer; the data regs clear on their own clr.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_data_reg #(.W(WORD_SIZE)) u_main (
        .clk   (clk),
        .rst_n (reset),
        .clr   (flush),
        .ld    (ld_main),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.W(WORD_SIZE)) u_skid (
        .clk   (clk),
        .rst_n (reset),
        .clr   (flush),
        .ld    (ld_skid),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_data = main_q;
    assign count    = state_q;

endmodule
